// File: rtl/calculate_exp_sigma.sv
// calculate_exp_sigma
//
// Fills a 1024-entry exponential look-up table. On a start request it evaluates
// r = exp(-sigma) in Q1.17 fixed point with a short Horner chain (one multiply
// per cycle), then streams E[k] = r^k for k = 0..1023 as address/data pairs,
// one pair per cycle, and finishes with a one-cycle oDone pulse.
//
// Ports
//   CLK     in   1   clock, all state updates on the rising edge
//   RST     in   1   asynchronous active-high reset
//   iSigma  in   18  sigma, unsigned Q2.16, sampled only on the accepted start edge
//   iStart  in   1   start request, level-sampled while idle
//   oData   out  18  table value E[oAddr], unsigned Q1.17 (1.0 = 131072)
//   oAddr   out  10  table address
//   oDone   out  1   registered one-cycle pulse after the last entry
module calculate_exp_sigma (
  input  logic        CLK,
  input  logic        RST,
  input  logic [17:0] iSigma,
  input  logic        iStart,
  output logic [17:0] oData,
  output logic [9:0]  oAddr,
  output logic        oDone
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    C1    = 3'd1,
    C2    = 3'd2,
    C3    = 3'd3,
    C4    = 3'd4,
    WRITE = 3'd5,
    DONE  = 3'd6
  } stateT;

  localparam logic [17:0] ONE       = 18'd131072;
  // 1/3 in Q1.17, the innermost Horner coefficient
  localparam logic [17:0] ONE_THIRD = 18'd43691;
  localparam logic [9:0]  LAST_ADDR = 10'd1023;

  stateT       state, nextState;
  logic [17:0] x, a, h3, h2, r;
  logic [17:0] xNext, aNext, h3Next, h2Next, rNext;
  logic [17:0] dataNext;
  logic [9:0]  addrNext;
  logic        doneNext;

  // Unsigned Q1.17 multiply: full 36-bit product, truncated back to 18 bits.
  function automatic logic [17:0] mulQ(input logic [17:0] opA, input logic [17:0] opB);
    logic [35:0] product;
    product = {18'd0, opA} * {18'd0, opB};
    return 18'(product >> 17);
  endfunction

  // State and datapath registers; reset clears everything so an aborted run
  // leaves no trace and never produces a done pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      x     <= '0;
      a     <= '0;
      h3    <= '0;
      h2    <= '0;
      r     <= '0;
      oData <= '0;
      oAddr <= '0;
      oDone <= 1'b0;
    end else begin
      state <= nextState;
      x     <= xNext;
      a     <= aNext;
      h3    <= h3Next;
      h2    <= h2Next;
      r     <= rNext;
      oData <= dataNext;
      oAddr <= addrNext;
      oDone <= doneNext;
    end
  end

  // Sequencing: four Horner cycles, then one table entry per cycle until the
  // last address, then a single DONE cycle before accepting another start.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (iStart) nextState = C1;
      C1:      nextState = C2;
      C2:      nextState = C3;
      C3:      nextState = C4;
      C4:      nextState = WRITE;
      WRITE:   if (oAddr == LAST_ADDR) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath next values. exp(-x) ~ 1 - x(1 - x/2(1 - x/3(1 - x/4))), evaluated
  // from the inside out. Outside the active states everything holds, so the
  // final address/data pair stays visible until the next run starts.
  always_comb begin
    xNext    = x;
    aNext    = a;
    h3Next   = h3;
    h2Next   = h2;
    rNext    = r;
    dataNext = oData;
    addrNext = oAddr;
    doneNext = 1'b0;
    unique case (state)
      IDLE: begin
        if (iStart) begin
          // Q2.16 -> Q1.17 is a left shift; sigma >= 1.0 saturates just below 1.0
          xNext = (iSigma < 18'd65536) ? {iSigma[15:0], 1'b0} : 18'h1FFFE;
        end
      end
      C1: aNext  = mulQ(x, ONE - (x >> 2));
      C2: h3Next = ONE - mulQ(a, ONE_THIRD);
      C3: h2Next = ONE - (mulQ(x, h3) >> 1);
      C4: begin
        rNext    = ONE - mulQ(x, h2);
        addrNext = '0;
        dataNext = ONE;
      end
      WRITE: begin
        if (oAddr == LAST_ADDR) begin
          doneNext = 1'b1;
        end else begin
          addrNext = oAddr + 10'd1;
          dataNext = mulQ(oData, r);
        end
      end
      DONE:    ;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_calculate_exp_sigma.sv
// tb_calculate_exp_sigma
//
// Self-checking bench for calculate_exp_sigma. Edges of a run are numbered with
// the accepted start edge as edge 1: address k appears after edge 5+k and the
// done pulse is visible after edge 1029. Expected tables come from a plain
// arithmetic model of exp(-sigma) and its powers.
module tb_calculate_exp_sigma;

  logic        CLK = 1'b0;
  logic        RST;
  logic [17:0] iSigma;
  logic        iStart;
  logic [17:0] oData;
  logic [9:0]  oAddr;
  logic        oDone;

  int     checks   = 0;
  int     failures = 0;
  longint modelE[1024];
  logic [17:0] capturedE1, capturedE2;

  typedef struct {
    logic [17:0] sigma;
    int          holdEdges;
    int          pulseEdge;
    bit          restartAtDone;
    longint      expE1;
    longint      expE2;
  } vecT;

  calculate_exp_sigma dut (
    .CLK   (CLK),
    .RST   (RST),
    .iSigma(iSigma),
    .iStart(iStart),
    .oData (oData),
    .oAddr (oAddr),
    .oDone (oDone)
  );

  always #5 CLK = ~CLK;

  // Q1.17 product with truncation to 18 bits.
  function automatic longint mq(input longint p, input longint q);
    return ((p * q) / 131072) % 262144;
  endfunction

  // exp(-sigma) by Horner's rule on 1 - x + x^2/2 - x^3/6 + x^4/24, then powers.
  function automatic void buildModel(input logic [17:0] sigma);
    longint x, a, h3, h2, r;
    x  = (sigma >= 18'd65536) ? 131070 : longint'(sigma) * 2;
    a  = mq(x, 131072 - x / 4);
    h3 = 131072 - mq(a, 43691);
    h2 = 131072 - mq(x, h3) / 2;
    r  = 131072 - mq(x, h2);
    modelE[0] = 131072;
    for (int k = 1; k < 1024; k++) modelE[k] = mq(modelE[k-1], r);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge CLK);
    RST = 1'b1;
    iStart = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
  endtask

  // One complete run; iSigma is scrambled after the start edge to show it is
  // only sampled once. Optional extra start pulse mid-run, and optional start
  // request raised during the done cycle (must wait for the following idle edge).
  task automatic applyStimulus(input logic [17:0] sigma, input int holdEdges, input int pulseEdge,
                               input bit restartAtDone, input string name);
    int badEntries, firstBad, donePulses, doneEdge, lastEdge, expAddr;
    buildModel(sigma);
    badEntries = 0;
    firstBad   = -1;
    donePulses = 0;
    doneEdge   = -1;
    lastEdge   = restartAtDone ? 1036 : 1032;
    @(negedge CLK);
    iSigma = sigma;
    iStart = 1'b1;
    for (int n = 1; n <= lastEdge; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      iStart = (n < holdEdges) || (n == pulseEdge) || (restartAtDone && n >= 1029 && n < 1031);
      if (n == 2) iSigma = 18'($urandom);
      if (n >= 5 && n <= 1032) begin
        expAddr = (n - 5 > 1023) ? 1023 : n - 5;
        if (oAddr !== 10'(expAddr) || oData !== 18'(modelE[expAddr])) begin
          badEntries++;
          if (firstBad < 0) firstBad = n;
        end
        if (n == 6) capturedE1 = oData;
        if (n == 7) capturedE2 = oData;
      end
      if (oDone === 1'b1) begin
        donePulses++;
        if (doneEdge < 0) doneEdge = n;
      end
      if (restartAtDone && n == 1034) checkOutput({name, " addr held until restart"}, 64'(oAddr), 64'd1023);
      if (restartAtDone && n == 1035) begin
        checkOutput({name, " restart addr0"}, 64'(oAddr), 64'd0);
        checkOutput({name, " restart data0"}, 64'(oData), 64'd131072);
      end
    end
    iStart = 1'b0;
    if (badEntries != 0) $display("[TB] %s first wrong entry after edge %0d", name, firstBad);
    checkOutput({name, " wrong table entries"}, 64'(badEntries), 64'd0);
    checkOutput({name, " done pulses"}, 64'(donePulses), 64'd1);
    checkOutput({name, " done edge"}, 64'(doneEdge), 64'd1029);
    if (!restartAtDone) begin
      checkOutput({name, " held addr"}, 64'(oAddr), 64'd1023);
      checkOutput({name, " held data"}, 64'(oData), 64'(modelE[1023]));
    end
  endtask

  // Reset in the middle of the table walk must clear outputs immediately and
  // suppress the done pulse; a fresh start then rebuilds the table from zero.
  task automatic resetAbort();
    int donePulses;
    @(negedge CLK);
    iSigma = 18'd3408;
    iStart = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    iStart = 1'b0;
    for (int n = 2; n <= 600; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (n >= 5 && oAddr == 10'd500) break;
    end
    checkOutput("abort reached addr 500", 64'(oAddr), 64'd500);
    #1 RST = 1'b1;
    #1;
    checkOutput("abort addr", 64'(oAddr), 64'd0);
    checkOutput("abort data", 64'(oData), 64'd0);
    checkOutput("abort done", 64'(oDone), 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    donePulses = 0;
    for (int n = 0; n < 1100; n++) begin
      @(negedge CLK);
      if (oDone !== 1'b0) donePulses++;
    end
    checkOutput("abort no done pulse", 64'(donePulses), 64'd0);
    checkOutput("abort idle addr", 64'(oAddr), 64'd0);
    applyStimulus(18'd3408, 1, 0, 1'b0, "after abort");
  endtask

  initial begin
    vecT vecs[5];
    logic [17:0] sigma;

    vecs[0] = '{18'd3408,  3, 0,   1'b0, 124431, 118126};
    vecs[1] = '{18'd0,     1, 0,   1'b0, 131072, 131072};
    vecs[2] = '{18'd70000, 1, 0,   1'b0, -1,     -1};
    vecs[3] = '{18'd3408,  1, 300, 1'b0, 124431, 118126};
    vecs[4] = '{18'd12345, 2, 0,   1'b1, -1,     -1};

    RST    = 1'b1;
    iStart = 1'b0;
    iSigma = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("reset data", 64'(oData), 64'd0);
    checkOutput("reset addr", 64'(oAddr), 64'd0);
    checkOutput("reset done", 64'(oDone), 64'd0);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    checkOutput("idle data", 64'(oData), 64'd0);
    checkOutput("idle addr", 64'(oAddr), 64'd0);
    checkOutput("idle done", 64'(oDone), 64'd0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].sigma, vecs[i].holdEdges, vecs[i].pulseEdge, vecs[i].restartAtDone,
                    $sformatf("vec%0d", i));
      if (vecs[i].expE1 >= 0) begin
        checkOutput($sformatf("vec%0d E1", i), 64'(capturedE1), 64'(vecs[i].expE1));
        checkOutput($sformatf("vec%0d E2", i), 64'(capturedE2), 64'(vecs[i].expE2));
      end
      if (vecs[i].restartAtDone) doReset();
    end

    resetAbort();

    for (int i = 0; i < 4; i++) begin
      sigma = (i < 2) ? 18'($urandom_range(0, 65535)) : 18'($urandom_range(65536, 262143));
      applyStimulus(sigma, 1 + (i % 3), 0, 1'b0, $sformatf("rand%0d sigma=%0d", i, sigma));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
